// File: rtl/matrix_scan_if.sv
// Board-side pins of the LED matrix scanner: serial column chain, row select and frame marker.
interface matrix_scan_if;
   logic       ser_data;
   logic       ser_clk;
   logic       ser_latch;
   logic [3:0] row_sel;
   logic       row_en;
   logic       frame_start;

   modport master (output ser_data, ser_clk, ser_latch, row_sel, row_en, frame_start);
   modport slave  (input  ser_data, ser_clk, ser_latch, row_sel, row_en, frame_start);
endinterface

// File: rtl/matrix_scan.sv
// Row-multiplexed 16x16 LED renderer for ball and paddles with a per-frame input snapshot.
// Optional ball trail pixel is enabled by defining BALL_TRAIL_EN.
module matrix_scan #(
   parameter int unsigned DWELL    = 64,
   parameter int unsigned PADDLE_H = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    ball_x,
   input  logic [3:0]    ball_y,
   input  logic [3:0]    lpad_y,
   input  logic [3:0]    rpad_y,
   matrix_scan_if.master pins
);

   localparam logic [1:0] StLoad    = 2'd0;
   localparam logic [1:0] StShift   = 2'd1;
   localparam logic [1:0] StLatch   = 2'd2;
   localparam logic [1:0] StDisplay = 2'd3;

   localparam logic [7:0] DwellLast = 8'(DWELL - 1);
   localparam logic [4:0] PadSpan   = 5'(PADDLE_H - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  row_q, row_d;
   logic [3:0]  row_sel_q, row_sel_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [7:0]  dwell_q, dwell_d;
   logic [15:0] pat_q, pat_d;

   logic [3:0]  snap_bx_q, snap_by_q, snap_lp_q, snap_rp_q;
   logic        snap_now;
   logic [3:0]  eff_bx, eff_by, eff_lp, eff_rp;
   logic [15:0] row_pat;

   // 5-bit compare so a paddle running past row 15 is clipped instead of wrapping.
   function automatic logic in_paddle(input logic [3:0] row, input logic [3:0] top);
      return ({1'b0, row} >= {1'b0, top}) && ({1'b0, row} <= ({1'b0, top} + PadSpan));
   endfunction

   assign snap_now = !reset && (state_q == StLoad) && (row_q == 4'd0);

   // Row 0 renders from the values being captured this cycle.
   always_comb begin
      eff_bx = snap_now ? ball_x : snap_bx_q;
      eff_by = snap_now ? ball_y : snap_by_q;
      eff_lp = snap_now ? lpad_y : snap_lp_q;
      eff_rp = snap_now ? rpad_y : snap_rp_q;
   end

`ifdef BALL_TRAIL_EN
   logic [3:0] trail_x_q, trail_y_q;
   logic       trail_v_q, snap_v_q;
   logic [3:0] eff_tx, eff_ty;
   logic       eff_tv;

   always_comb begin
      eff_tx = snap_now ? snap_bx_q : trail_x_q;
      eff_ty = snap_now ? snap_by_q : trail_y_q;
      eff_tv = snap_now ? snap_v_q  : trail_v_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         trail_x_q <= '0;
         trail_y_q <= '0;
         trail_v_q <= 1'b0;
         snap_v_q  <= 1'b0;
      end else if (snap_now) begin
         trail_x_q <= snap_bx_q;
         trail_y_q <= snap_by_q;
         trail_v_q <= snap_v_q;
         snap_v_q  <= 1'b1;
      end
   end
`endif

   always_comb begin
      row_pat = '0;
      if (row_q == eff_by) row_pat[eff_bx] = 1'b1;
      if (in_paddle(row_q, eff_lp)) row_pat[0] = 1'b1;
      if (in_paddle(row_q, eff_rp)) row_pat[15] = 1'b1;
`ifdef BALL_TRAIL_EN
      if (eff_tv && (row_q == eff_ty)) row_pat[eff_tx] = 1'b1;
`endif
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      row_sel_d = row_sel_q;
      cnt_d     = cnt_q;
      dwell_d   = dwell_q;
      pat_d     = pat_q;
      case (state_q)
         StLoad: begin
            pat_d   = row_pat;
            cnt_d   = '0;
            state_d = StShift;
         end
         StShift: begin
            cnt_d = cnt_q + 5'd1;
            // Odd count is phase B; advance to the next column after the rising edge.
            if (cnt_q[0]) pat_d = {pat_q[14:0], 1'b0};
            if (cnt_q == 5'd31) begin
               state_d   = StLatch;
               row_sel_d = row_q;
            end
         end
         StLatch: begin
            dwell_d = '0;
            state_d = StDisplay;
         end
         default: begin
            dwell_d = dwell_q + 8'd1;
            if (dwell_q == DwellLast) begin
               row_d   = row_q + 4'd1;
               state_d = StLoad;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StLoad;
         row_q     <= '0;
         row_sel_q <= '0;
         cnt_q     <= '0;
         dwell_q   <= '0;
         pat_q     <= '0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         row_sel_q <= row_sel_d;
         cnt_q     <= cnt_d;
         dwell_q   <= dwell_d;
         pat_q     <= pat_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_bx_q <= '0;
         snap_by_q <= '0;
         snap_lp_q <= '0;
         snap_rp_q <= '0;
      end else if (snap_now) begin
         snap_bx_q <= ball_x;
         snap_by_q <= ball_y;
         snap_lp_q <= lpad_y;
         snap_rp_q <= rpad_y;
      end
   end

   assign pins.ser_data    = (state_q == StShift) & pat_q[15];
   assign pins.ser_clk     = (state_q == StShift) & cnt_q[0];
   assign pins.ser_latch   = (state_q == StLatch);
   assign pins.row_sel     = row_sel_q;
   assign pins.row_en      = (state_q == StDisplay);
   assign pins.frame_start = snap_now;

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan: models the external shift/latch chain and checks rendered rows.
module tb_matrix_scan;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] ball_x = 4'd5;
   logic [3:0] ball_y = 4'd9;
   logic [3:0] lpad_y = 4'd0;
   logic [3:0] rpad_y = 4'd13;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [15:0] sr = '0;
   logic        mon_prev = 1'b0;
   logic [15:0] latched [16];

   matrix_scan_if pins ();

   matrix_scan dut (
      .clk    (clk),
      .reset  (reset),
      .ball_x (ball_x),
      .ball_y (ball_y),
      .lpad_y (lpad_y),
      .rpad_y (rpad_y),
      .pins   (pins)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // External SIPO chain plus storage register, one latched word per row address.
   initial forever begin
      @(negedge clk);
      if (pins.ser_clk === 1'b1 && mon_prev === 1'b0) sr = {sr[14:0], pins.ser_data};
      if (pins.ser_latch === 1'b1) latched[pins.row_sel] = sr;
      mon_prev = pins.ser_clk;
   end

   task automatic wait_frame_start(output int at_cyc);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (pins.frame_start !== 1'b1 && n < 2000);
      at_cyc = cyc;
      if (pins.frame_start !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_start_timeout: got no pulse, required one within 2000 cycles");
      end
   endtask

   task automatic wait_display_row(input logic [3:0] r);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(pins.row_en === 1'b1 && pins.row_sel === r) && n < 2000);
      if (!(pins.row_en === 1'b1 && pins.row_sel === r)) begin
         n_checks++;
         n_fail++;
         $display("FAIL row_wait_timeout: row %0d never displayed", r);
      end
   endtask

   task automatic test_reset();
      logic [8:0] outs;
      repeat (3) begin
         @(posedge clk);
         #1;
         outs = {pins.ser_data, pins.ser_clk, pins.ser_latch, pins.row_sel, pins.row_en,
                 pins.frame_start};
         n_checks++;
         if (outs !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", outs);
         end
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (pins.frame_start !== 1'b1) begin
         n_fail++;
         $display("FAIL first_frame_start: got %b required 1", pins.frame_start);
      end
      for (int i = 0; i < 98; i++) begin
         if (i > 0) @(negedge clk);
         n_checks++;
         if (pins.row_en !== (i >= 34)) begin
            n_fail++;
            $display("FAIL row_en_cycle%0d: got %b required %b", i, pins.row_en, (i >= 34));
         end
      end
   endtask

   task automatic test_render();
      logic [15:0] exp_pat [16];
      int t;
      for (int r = 0; r < 16; r++) exp_pat[r] = 16'h0000;
      exp_pat[0] = 16'h0001; exp_pat[1] = 16'h0001; exp_pat[2] = 16'h0001;
      exp_pat[9] = 16'h0020;
      exp_pat[13] = 16'h8000; exp_pat[14] = 16'h8000; exp_pat[15] = 16'h8000;
      wait_frame_start(t);
      for (int r = 0; r < 16; r++) begin
         n_checks++;
         if (latched[r] !== exp_pat[r]) begin
            n_fail++;
            $display("FAIL render_row%0d: got %h required %h", r, latched[r], exp_pat[r]);
         end
      end
   endtask

   task automatic test_clip_overlap();
      logic [15:0] exp_pat [16];
      int t;
      @(negedge clk);
      ball_x = 4'd0; ball_y = 4'd1; lpad_y = 4'd0; rpad_y = 4'd14;
      for (int r = 0; r < 16; r++) exp_pat[r] = 16'h0000;
      exp_pat[0] = 16'h0001; exp_pat[1] = 16'h0001; exp_pat[2] = 16'h0001;
      exp_pat[14] = 16'h8000; exp_pat[15] = 16'h8000;
`ifdef BALL_TRAIL_EN
      exp_pat[9] = 16'h0020;
`endif
      wait_frame_start(t);
      wait_frame_start(t);
      for (int r = 0; r < 16; r++) begin
         n_checks++;
         if (latched[r] !== exp_pat[r]) begin
            n_fail++;
            $display("FAIL clip_row%0d: got %h required %h", r, latched[r], exp_pat[r]);
         end
      end
   endtask

   task automatic test_snapshot();
      logic [15:0] exp_pat [16];
      int t5, t6, t7;
      @(negedge clk);
      ball_x = 4'd5; ball_y = 4'd9; lpad_y = 4'd0; rpad_y = 4'd13;
      for (int r = 0; r < 16; r++) exp_pat[r] = 16'h0000;
      exp_pat[0] = 16'h0001; exp_pat[1] = 16'h0001; exp_pat[2] = 16'h0001;
      exp_pat[9] = 16'h0020;
      exp_pat[13] = 16'h8000; exp_pat[14] = 16'h8000; exp_pat[15] = 16'h8000;
      wait_frame_start(t5);
      wait_display_row(4'd3);
      ball_x = 4'd10;
      wait_frame_start(t6);
      n_checks++;
      if (t6 - t5 !== 1568) begin
         n_fail++;
         $display("FAIL frame_period: got %0d required 1568", t6 - t5);
      end
      for (int r = 0; r < 16; r++) begin
         n_checks++;
         if (latched[r] !== exp_pat[r]) begin
            n_fail++;
            $display("FAIL snap_old_row%0d: got %h required %h", r, latched[r], exp_pat[r]);
         end
      end
`ifdef BALL_TRAIL_EN
      exp_pat[9] = 16'h0420;
`else
      exp_pat[9] = 16'h0400;
`endif
      wait_frame_start(t7);
      for (int r = 0; r < 16; r++) begin
         n_checks++;
         if (latched[r] !== exp_pat[r]) begin
            n_fail++;
            $display("FAIL snap_new_row%0d: got %h required %h", r, latched[r], exp_pat[r]);
         end
      end
   endtask

   // Entered in the LOAD cycle of row 0.
   task automatic test_serial();
      logic        d_a = 1'b0;
      logic        prev;
      logic        exp_clk;
      logic [15:0] got = '0;
      int          rises = 0;
      prev = pins.ser_clk;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         exp_clk = (i % 2 == 1);
         n_checks++;
         if (pins.ser_clk !== exp_clk || pins.row_en !== 1'b0 || pins.ser_latch !== 1'b0) begin
            n_fail++;
            $display("FAIL shift_cycle%0d: got clk/en/latch %b%b%b required %b00", i,
                     pins.ser_clk, pins.row_en, pins.ser_latch, exp_clk);
         end
         if (!exp_clk) d_a = pins.ser_data;
         else begin
            n_checks++;
            if (pins.ser_data !== d_a) begin
               n_fail++;
               $display("FAIL data_stable%0d: got %b required %b", i, pins.ser_data, d_a);
            end
         end
         if (pins.ser_clk === 1'b1 && prev === 1'b0) begin
            rises++;
            got = {got[14:0], pins.ser_data};
         end
         prev = pins.ser_clk;
      end
      @(negedge clk);
      n_checks++;
      if ({pins.ser_latch, pins.ser_clk, pins.row_en, pins.row_sel} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL latch_cycle: got latch/clk/en/row %b%b%b/%0d required 100/0",
                  pins.ser_latch, pins.ser_clk, pins.row_en, pins.row_sel);
      end
      @(negedge clk);
      n_checks++;
      if (pins.ser_latch !== 1'b0 || pins.row_en !== 1'b1) begin
         n_fail++;
         $display("FAIL after_latch: got latch/en %b%b required 01", pins.ser_latch, pins.row_en);
      end
      n_checks++;
      if (rises !== 16) begin
         n_fail++;
         $display("FAIL rise_count: got %0d required 16", rises);
      end
      n_checks++;
      if (got !== 16'h0001) begin
         n_fail++;
         $display("FAIL shifted_word: got %h required 0001", got);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [15:0] exp_pat [16];
      logic [8:0]  outs;
      int          n = 0;
      int          t;
      wait_display_row(4'd6);
      while (pins.row_en === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (9) @(negedge clk);
      n_checks++;
      if (pins.ser_clk !== 1'b0 || pins.row_en !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_shift_phase: got clk/en %b%b required 00", pins.ser_clk, pins.row_en);
      end
      reset = 1'b1;
      ball_x = 4'd3; ball_y = 4'd4;
      @(posedge clk);
      #1;
      outs = {pins.ser_data, pins.ser_clk, pins.ser_latch, pins.row_sel, pins.row_en,
              pins.frame_start};
      n_checks++;
      if (outs !== 9'd0) begin
         n_fail++;
         $display("FAIL abort_outputs: got %b required 0", outs);
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (pins.frame_start !== 1'b1 || pins.row_sel !== 4'd0) begin
         n_fail++;
         $display("FAIL restart: got fs/row %b/%0d required 1/0", pins.frame_start, pins.row_sel);
      end
      @(negedge clk);
      ball_x = 4'd12; ball_y = 4'd6;
      for (int r = 0; r < 16; r++) exp_pat[r] = 16'h0000;
      exp_pat[0] = 16'h0001; exp_pat[1] = 16'h0001; exp_pat[2] = 16'h0001;
      exp_pat[4] = 16'h0008;
      exp_pat[13] = 16'h8000; exp_pat[14] = 16'h8000; exp_pat[15] = 16'h8000;
      wait_frame_start(t);
      for (int r = 0; r < 16; r++) begin
         n_checks++;
         if (latched[r] !== exp_pat[r]) begin
            n_fail++;
            $display("FAIL post_reset_row%0d: got %h required %h", r, latched[r], exp_pat[r]);
         end
      end
`ifdef BALL_TRAIL_EN
      exp_pat[4] = 16'h0008;
`else
      exp_pat[4] = 16'h0000;
`endif
      exp_pat[6] = 16'h1000;
      wait_frame_start(t);
      for (int r = 0; r < 16; r++) begin
         n_checks++;
         if (latched[r] !== exp_pat[r]) begin
            n_fail++;
            $display("FAIL trail_row%0d: got %h required %h", r, latched[r], exp_pat[r]);
         end
      end
   endtask

   initial begin
      for (int r = 0; r < 16; r++) latched[r] = '0;
      test_reset();
      test_render();
      test_clip_overlap();
      test_snapshot();
      test_serial();
      test_reset_mid_shift();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
